// File: rtl/i2c_cfg_pkg.sv
`default_nettype none
// i2c_cfg_pkg -- shared FSM state, delay marker and entry layout helpers. Rev 1.0
package i2c_cfg_pkg;

  typedef enum logic [3:0] {
    ST_PWRUP = 4'd0,
    ST_IDLE  = 4'd1,
    ST_START = 4'd2,
    ST_BYTE  = 4'd3,
    ST_ACK   = 4'd4,
    ST_STOP  = 4'd5,
    ST_GAP   = 4'd6,
    ST_WAIT  = 4'd7,
    ST_DONE  = 4'd8,
    ST_ERROR = 4'd9
  } cfg_state_e;

  localparam logic [7:0] DELAY_DEV_ID = 8'hFF;

  function automatic int entry_bytes(input int addr_bytes, input int data_bytes);
    return 1 + addr_bytes + data_bytes;
  endfunction

  function automatic int dev_lsb(input int addr_bytes, input int data_bytes);
    return 8 * (addr_bytes + data_bytes);
  endfunction

endpackage
`default_nettype wire

// File: rtl/i2c_config_engine_bit_timer.sv
`default_nettype none
// i2c_bit_timer -- quarter-bit strobes and SCL level for one I2C bit period. Rev 1.0
module i2c_bit_timer #(
  parameter int CLK_FREQ = 100_000_000,
  parameter int I2C_FREQ = 100_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en_i,
  output logic [1:0] quarter_o,
  output logic       q_last_o,
  output logic       bit_last_o,
  output logic       scl_o
);
  localparam int Q  = (CLK_FREQ / I2C_FREQ) / 4;
  localparam int QW = (Q > 1) ? $clog2(Q) : 1;

  logic [QW-1:0] cnt_q;
  logic [1:0]    quarter_q;

  // Held at the start of quarter 0 while disabled, so every bit state begins aligned.
  always_ff @(posedge clk) begin
    if (rst || !en_i) begin
      cnt_q     <= '0;
      quarter_q <= '0;
    end else if (cnt_q == QW'(Q - 1)) begin
      cnt_q     <= '0;
      quarter_q <= quarter_q + 2'd1;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign quarter_o  = quarter_q;
  assign q_last_o   = en_i && (cnt_q == QW'(Q - 1));
  assign bit_last_o = q_last_o && (quarter_q == 2'd3);
  assign scl_o      = (quarter_q == 2'd1) || (quarter_q == 2'd2);

endmodule
`default_nettype wire

// File: rtl/i2c_config_engine.sv
`default_nettype none
// i2c_config_engine -- walks a register table and writes each entry over I2C,
// with NACK retries and millisecond delay entries. Rev 1.0
module i2c_config_engine
  import i2c_cfg_pkg::*;
#(
  parameter int  CLK_FREQ   = 100_000_000,
  parameter int  I2C_FREQ   = 100_000,
  parameter int  ADDR_BYTES = 2,
  parameter int  DATA_BYTES = 1,
  parameter int  MAX_RETRY  = 3,
  parameter int  PWRUP_MS   = 1,
  parameter int  IDX_W      = 10,
  localparam int EW         = 8 * (1 + ADDR_BYTES + DATA_BYTES)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_start,
  input  logic [IDX_W-1:0] cfg_size,
  output logic [IDX_W-1:0] cfg_index,
  input  logic [EW-1:0]    cfg_data,
  output logic             cfg_done,
  output logic             cfg_error,
  output logic [IDX_W-1:0] err_index,
  output logic             i2c_sclk,
  output logic             i2c_sdat_o,
  output logic             i2c_sdat_oe,
  input  logic             i2c_sdat_i
);
  localparam int          NBYTES     = entry_bytes(ADDR_BYTES, DATA_BYTES);
  localparam int          DEV_LSB    = dev_lsb(ADDR_BYTES, DATA_BYTES);
  localparam int          RW         = $clog2(MAX_RETRY + 1) + 1;
  localparam logic [2:0]  LAST_BYTE  = 3'(NBYTES - 1);
  localparam logic [31:0] MS_CLKS    = 32'(CLK_FREQ / 1000);
  localparam logic [31:0] PWRUP_CLKS = 32'(longint'(PWRUP_MS) * CLK_FREQ / 1000);

  cfg_state_e       state_q, state_d;
  logic [IDX_W-1:0] index_q, index_d, err_idx_q, err_idx_d;
  logic [RW-1:0]    retry_q, retry_d;
  logic [2:0]       byte_q, byte_d, bit_q, bit_d;
  logic [EW-1:0]    sh_q, sh_d;
  logic [31:0]      wait_q, wait_d;
  logic             nack_q, nack_d, done_q, done_d, error_q, error_d;
  logic             sclk_q, sclk_d, sdo_q, sdo_d, oe_q, oe_d;

  logic [1:0]  quarter;
  logic        q_last, bit_last, scl_lvl, timer_en;
  logic [31:0] delay_clks;

  assign timer_en   = !(state_q inside {ST_PWRUP, ST_IDLE, ST_DONE, ST_ERROR});
  assign delay_clks = {24'd0, sh_q[7:0]} * MS_CLKS;

  i2c_bit_timer #(
    .CLK_FREQ (CLK_FREQ),
    .I2C_FREQ (I2C_FREQ)
  ) u_bit_timer (
    .clk        (clk),
    .rst        (rst),
    .en_i       (timer_en),
    .quarter_o  (quarter),
    .q_last_o   (q_last),
    .bit_last_o (bit_last),
    .scl_o      (scl_lvl)
  );

  always_comb begin
    state_d   = state_q;
    index_d   = index_q;
    err_idx_d = err_idx_q;
    retry_d   = retry_q;
    byte_d    = byte_q;
    bit_d     = bit_q;
    sh_d      = sh_q;
    wait_d    = wait_q;
    nack_d    = nack_q;
    done_d    = done_q;
    error_d   = error_q;
    sclk_d    = 1'b1;
    sdo_d     = 1'b1;
    oe_d      = 1'b0;
    unique case (state_q)
      ST_PWRUP: begin
        if (wait_q + 32'd1 >= PWRUP_CLKS) begin
          wait_d  = '0;
          state_d = ST_IDLE;
        end else begin
          wait_d = wait_q + 32'd1;
        end
      end
      ST_IDLE: begin
        if (cfg_start) begin
          index_d = '0;
          done_d  = 1'b0;
          error_d = 1'b0;
          retry_d = '0;
        end else if (index_q < cfg_size) begin
          // The entry is captured here; the table may change underneath afterwards.
          sh_d    = cfg_data;
          byte_d  = '0;
          bit_d   = '0;
          wait_d  = '0;
          nack_d  = 1'b0;
          state_d = (cfg_data[DEV_LSB +: 8] == DELAY_DEV_ID) ? ST_WAIT : ST_START;
        end else begin
          done_d  = 1'b1;
          state_d = ST_DONE;
        end
      end
      ST_START: begin
        oe_d   = 1'b1;
        sdo_d  = (quarter == 2'd0);
        sclk_d = (quarter != 2'd3);
        if (bit_last) state_d = ST_BYTE;
      end
      ST_BYTE: begin
        oe_d   = 1'b1;
        sdo_d  = sh_q[EW-1];
        sclk_d = scl_lvl;
        if (bit_last) begin
          sh_d  = {sh_q[EW-2:0], 1'b0};
          bit_d = bit_q + 3'd1;
          if (bit_q == 3'd7) state_d = ST_ACK;
        end
      end
      ST_ACK: begin
        sclk_d = scl_lvl;
        if (quarter == 2'd1 && q_last) nack_d = i2c_sdat_i;
        if (bit_last) begin
          if (nack_q || byte_q == LAST_BYTE) begin
            state_d = ST_STOP;
          end else begin
            byte_d  = byte_q + 3'd1;
            state_d = ST_BYTE;
          end
        end
      end
      ST_STOP: begin
        oe_d   = 1'b1;
        sdo_d  = quarter[1];
        sclk_d = (quarter != 2'd0);
        if (bit_last) state_d = ST_GAP;
      end
      ST_GAP: begin
        if (bit_last) begin
          if (!nack_q) begin
            index_d = index_q + 1'b1;
            retry_d = '0;
            state_d = ST_IDLE;
          end else if (retry_q < RW'(MAX_RETRY)) begin
            retry_d = retry_q + 1'b1;
            state_d = ST_IDLE;
          end else begin
            err_idx_d = index_q;
            error_d   = 1'b1;
            state_d   = ST_ERROR;
          end
        end
      end
      ST_WAIT: begin
        if (wait_q + 32'd1 >= delay_clks) begin
          index_d = index_q + 1'b1;
          retry_d = '0;
          state_d = ST_IDLE;
        end else begin
          wait_d = wait_q + 32'd1;
        end
      end
      ST_DONE, ST_ERROR: begin
        if (cfg_start) begin
          index_d = '0;
          done_d  = 1'b0;
          error_d = 1'b0;
          retry_d = '0;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_PWRUP;
    endcase
  end

  // Bus outputs are registered so SCL/SDA never glitch; reset releases them on the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_PWRUP;
      index_q   <= '0;
      err_idx_q <= '0;
      retry_q   <= '0;
      byte_q    <= '0;
      bit_q     <= '0;
      sh_q      <= '0;
      wait_q    <= '0;
      nack_q    <= 1'b0;
      done_q    <= 1'b0;
      error_q   <= 1'b0;
      sclk_q    <= 1'b1;
      sdo_q     <= 1'b1;
      oe_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      index_q   <= index_d;
      err_idx_q <= err_idx_d;
      retry_q   <= retry_d;
      byte_q    <= byte_d;
      bit_q     <= bit_d;
      sh_q      <= sh_d;
      wait_q    <= wait_d;
      nack_q    <= nack_d;
      done_q    <= done_d;
      error_q   <= error_d;
      sclk_q    <= sclk_d;
      sdo_q     <= sdo_d;
      oe_q      <= oe_d;
    end
  end

  assign cfg_index   = index_q;
  assign cfg_done    = done_q;
  assign cfg_error   = error_q;
  assign err_index   = err_idx_q;
  assign i2c_sclk    = sclk_q;
  assign i2c_sdat_o  = sdo_q;
  assign i2c_sdat_oe = oe_q;

endmodule
`default_nettype wire

// File: doc/i2c_config_engine.md
I2C_CONFIG_ENGINE -- requirements
Module: i2c_config_engine

Interface
REQ-001 SHALL have parameter CLK_FREQ, default 100_000_000, system clock in Hz.
REQ-002 SHALL have parameter I2C_FREQ, default 100_000, SCL frequency in Hz (≤400_000).
REQ-003 SHALL have parameter ADDR_BYTES, default 2, register-address bytes per entry (1 or 2).
REQ-004 SHALL have parameter DATA_BYTES, default 1, register-data bytes per entry (1 or 2).
REQ-005 SHALL have parameter MAX_RETRY, default 3, re-attempts of a NACKed entry.
REQ-006 SHALL have parameter PWRUP_MS, default 1, settle delay after reset in ms.
REQ-007 SHALL have parameter IDX_W, default 10, table index width.
REQ-008 SHALL have derived localparam EW = 8*(1+ADDR_BYTES+DATA_BYTES), the entry width.
REQ-009 The port list SHALL be, one per line:
- clk  in  1  system clock; one clock domain.
- rst  in  1  synchronous, active-high reset.
- cfg_start  in  1  pulse; restarts the table from index 0 when idle, done or error.
- cfg_size  in  IDX_W  number of table entries.
- cfg_index  out  IDX_W  entry being sent.
- cfg_data  in  EW  entry: {dev_id, reg_addr, reg_data}, MSB first.
- cfg_done  out  1  all entries acknowledged.
- cfg_error  out  1  an entry exhausted its retries.
- err_index  out  IDX_W  index of the failed entry.
- i2c_sclk  out  1  SCL, open-drain intent; driven 1 when idle.
- i2c_sdat_o  out  1  SDA output value.
- i2c_sdat_oe  out  1  SDA output enable; 0 releases the line.
- i2c_sdat_i  in  1  SDA input, already synchronised.

Function
REQ-010 Bit period T = CLK_FREQ/I2C_FREQ clocks, split into four quarters of Q = T/4 clocks each.
REQ-011 Within each bit, SDA SHALL change at quarter 0 (SCL low), SCL SHALL be high in quarters 1–2, and SDA SHALL be sampled on the last clock of quarter 1.
REQ-012 The FSM states SHALL be PWRUP, IDLE, START, BYTE, ACK, STOP, GAP, WAIT, DONE and ERROR.
REQ-013 PWRUP SHALL count PWRUP_MS*CLK_FREQ/1000 clocks, then go to IDLE.
REQ-014 IDLE SHALL go to START if cfg_index < cfg_size, and to DONE otherwise; cfg_size = 0 SHALL give DONE directly.
REQ-015 START SHALL drive SDA low while SCL is high for one bit, then go to BYTE with byte_cnt = 0.
REQ-016 BYTE SHALL shift 8 bits MSB-first from byte byte_cnt of cfg_data, then go to ACK.
REQ-017 ACK SHALL release SDA (oe = 0) and sample it; a sampled 1 is a NACK.
- NACK → STOP immediately.
- ACK with byte_cnt < total−1 → byte_cnt+1, BYTE.
- ACK on the last byte → STOP.
REQ-018 STOP SHALL drive SDA low→high while SCL is high, then go to GAP, which holds the bus idle for one T.
REQ-019 After GAP, a successful entry SHALL increment cfg_index and clear retry_cnt.
REQ-020 After GAP, a NACKed entry with retry_cnt < MAX_RETRY SHALL increment retry_cnt and re-send the same index.
REQ-021 After GAP, a NACKed entry with retries exhausted SHALL latch err_index, set cfg_error and go to ERROR.
REQ-022 Delay entry: dev_id == 8'hFF SHALL emit no bus traffic; WAIT SHALL hold for reg_data (low 8 bits) ms, then cfg_index SHALL increment.
REQ-023 DONE and ERROR SHALL be sticky until cfg_start or rst.
REQ-024 cfg_start SHALL clear cfg_index, cfg_done, cfg_error and retry_cnt, then go to IDLE; cfg_start mid-transfer SHALL be ignored.
REQ-025 The SCL quarter counter SHALL run only outside PWRUP, IDLE, DONE and ERROR, and SHALL wrap at Q−1.
REQ-026 cfg_data SHALL be read only at the START of an entry and held in a shift register, so a table change mid-entry has no effect.

Reset
REQ-027 rst SHALL force PWRUP and cfg_index = 0, and clear all counters.
REQ-028 During rst: cfg_done = 0, cfg_error = 0, err_index = 0, i2c_sclk = 1, i2c_sdat_o = 1, i2c_sdat_oe = 0.
REQ-029 rst asserted mid-byte SHALL release both lines within one clock; no STOP is generated.

Structure
REQ-030 A shared package i2c_cfg_pkg SHALL hold the FSM state enum, the delay-entry marker 8'hFF and the entry field-offset helpers.
REQ-031 One sub-module, i2c_bit_timer, SHALL generate the quarter strobes and the SCL level from CLK_FREQ and I2C_FREQ.

Verification
REQ-032 Setup: CLK_FREQ = 4_000_000, I2C_FREQ = 100_000, PWRUP_MS = 1, slave model ACKs all; table of 3 entries {78,3008,02}. Required: three 4-byte frames with exact START/STOP edges, cfg_done at end, cfg_index = 3.
REQ-033 Slave NACKs the 2nd byte twice, then ACKs. Required: three attempts of index 0, cfg_error = 0, cfg_done = 1.
REQ-034 Slave always NACKs entry 1, MAX_RETRY = 3. Required: 4 attempts, then cfg_error = 1, err_index = 1, no traffic afterwards.
REQ-035 Entry {FF,0000,05}. Required: no SCL edges for 5 ms ±1 T, then the next entry is sent.
REQ-036 Assert rst during the 3rd bit of the address byte. Required: i2c_sclk = 1 and oe = 0 the next clock, then PWRUP and a restart from index 0.
REQ-037 Pulse cfg_start in DONE. Required: the full table is resent. Pulse cfg_start mid-BYTE. Required: no effect.
